mips_cpu_bus_core: RTL and testbench

Multi-cycle MIPS-I subset CPU (module `mips_cpu_bus_core`) with a single Avalon-style 32-bit memory-mapped master port shared by instruction fetch and data access. It is the top-level processor of the design: it boots from 0xBFC00000, runs until it jumps to address 0, then drops `active`. `register_v0` exposes $2 for system-level checking.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_regfile.sv | 40 ++++
 rtl/mips_cpu_bus_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_cpu_bus_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multi-cycle MIPS-I bus core: opcode and funct
// encodings, the FSM state type, the boot address and the bus byte-swap.
// No ports; imported by mips_regfile and mips_cpu_bus_core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // The bus carries the lowest-addressed (most significant) byte in lane
  // [7:0], so every word crossing the bus is byte-reversed.
  function automatic logic [31:0] byteSwap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile
// 32 x 32-bit general purpose register file. $0 is never written so it
// always reads zero.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset (clears all registers)
//   i_raddrA/o_rdataA   async read port A (rs)
//   i_raddrB/o_rdataB   async read port B (rt)
//   i_we/i_waddr/i_wdata synchronous write port
//   o_v0                live contents of $2
module mips_regfile
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_raddrA,
  output logic [31:0] o_rdataA,
  input  logic [4:0]  i_raddrB,
  output logic [31:0] o_rdataB,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_v0
);

  logic [31:0] r_regs [32];

  // Single write port; writes aimed at $0 are dropped so it stays zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdataA = r_regs[i_raddrA];
  assign o_rdataB = r_regs[i_raddrB];
  assign o_v0     = r_regs[2];

endmodule

// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core
// Multi-cycle MIPS-I subset CPU with one Avalon-style master port shared by
// instruction fetch and data access. Boots at RESET_VECTOR, halts when it
// fetches from address 0.
// Ports:
//   clk, reset (async, active-low)
//   active        high until the core halts
//   register_v0   live $2
//   address/read/write/byteenable/writedata   master request
//   waitrequest   slave stall, request held while high
//   readdata      read data, valid the cycle after acceptance
module mips_cpu_bus_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_t      r_state, w_stateNext;
  logic [31:0] r_pc, r_ir, r_branchTarget;
  logic        r_stalled, r_branchPending;

  logic [31:0] w_instr, w_rsVal, w_rtVal, w_immSext, w_immZext;
  logic [31:0] w_pcPlus4, w_pcPlus8, w_branchTarget, w_jTarget, w_memAddr;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_index;

  logic [31:0] w_aluResult, w_jumpTarget, w_rfWdata;
  logic [4:0]  w_wbAddr, w_rfWaddr;
  logic        w_wbEn, w_isLoad, w_isStore, w_jump, w_rfWe, w_advance;

  // Readdata is only guaranteed on the first EXEC cycle; if a load/store
  // stalls there, the latched copy keeps the decode stable.
  assign w_instr   = r_stalled ? r_ir : byteSwap(readdata);
  assign w_op      = w_instr[31:26];
  assign w_rs      = w_instr[25:21];
  assign w_rt      = w_instr[20:16];
  assign w_rd      = w_instr[15:11];
  assign w_shamt   = w_instr[10:6];
  assign w_funct   = w_instr[5:0];
  assign w_imm     = w_instr[15:0];
  assign w_index   = w_instr[25:0];
  assign w_immSext = {{16{w_imm[15]}}, w_imm};
  assign w_immZext = {16'h0000, w_imm};

  assign w_pcPlus4      = r_pc + 32'd4;
  assign w_pcPlus8      = r_pc + 32'd8;
  assign w_branchTarget = w_pcPlus4 + {w_immSext[29:0], 2'b00};
  assign w_jTarget      = {w_pcPlus4[31:28], w_index, 2'b00};
  assign w_memAddr      = w_rsVal + w_immSext;

  assign byteenable = 4'b1111;
  assign active     = !((r_state == HALT) || ((r_state == FETCH) && (r_pc == 32'd0)));

  mips_regfile u_regfile (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_raddrA (w_rs),
    .o_rdataA (w_rsVal),
    .i_raddrB (w_rt),
    .o_rdataB (w_rtVal),
    .i_we     (w_rfWe),
    .i_waddr  (w_rfWaddr),
    .i_wdata  (w_rfWdata),
    .o_v0     (register_v0)
  );

  // Decode and ALU: result, destination, memory kind and any control transfer
  // that the instruction schedules for after its delay slot.
  always_comb begin
    w_aluResult  = '0;
    w_wbEn       = 1'b0;
    w_wbAddr     = w_rt;
    w_isLoad     = 1'b0;
    w_isStore    = 1'b0;
    w_jump       = 1'b0;
    w_jumpTarget = w_branchTarget;
    case (w_op)
      OP_SPECIAL: begin
        w_wbAddr = w_rd;
        w_wbEn   = 1'b1;
        case (w_funct)
          FN_SLL:  w_aluResult = w_rtVal << w_shamt;
          FN_SRL:  w_aluResult = w_rtVal >> w_shamt;
          FN_ADDU: w_aluResult = w_rsVal + w_rtVal;
          FN_SUBU: w_aluResult = w_rsVal - w_rtVal;
          FN_AND:  w_aluResult = w_rsVal & w_rtVal;
          FN_OR:   w_aluResult = w_rsVal | w_rtVal;
          FN_XOR:  w_aluResult = w_rsVal ^ w_rtVal;
          FN_SLT:  w_aluResult = {31'b0, $signed(w_rsVal) < $signed(w_rtVal)};
          FN_SLTU: w_aluResult = {31'b0, w_rsVal < w_rtVal};
          FN_JR: begin
            w_wbEn       = 1'b0;
            w_jump       = 1'b1;
            w_jumpTarget = w_rsVal;
          end
          default: w_wbEn = 1'b0;
        endcase
      end
      OP_J: begin
        w_jump       = 1'b1;
        w_jumpTarget = w_jTarget;
      end
      OP_JAL: begin
        w_jump       = 1'b1;
        w_jumpTarget = w_jTarget;
        w_wbEn       = 1'b1;
        w_wbAddr     = 5'd31;
        w_aluResult  = w_pcPlus8;
      end
      OP_BEQ: w_jump = (w_rsVal == w_rtVal);
      OP_BNE: w_jump = (w_rsVal != w_rtVal);
      OP_ADDIU: begin
        w_wbEn      = 1'b1;
        w_aluResult = w_rsVal + w_immSext;
      end
      OP_SLTI: begin
        w_wbEn      = 1'b1;
        w_aluResult = {31'b0, $signed(w_rsVal) < $signed(w_immSext)};
      end
      OP_SLTIU: begin
        w_wbEn      = 1'b1;
        w_aluResult = {31'b0, w_rsVal < w_immSext};
      end
      OP_ANDI: begin
        w_wbEn      = 1'b1;
        w_aluResult = w_rsVal & w_immZext;
      end
      OP_ORI: begin
        w_wbEn      = 1'b1;
        w_aluResult = w_rsVal | w_immZext;
      end
      OP_XORI: begin
        w_wbEn      = 1'b1;
        w_aluResult = w_rsVal ^ w_immZext;
      end
      OP_LUI: begin
        w_wbEn      = 1'b1;
        w_aluResult = {w_imm, 16'h0000};
      end
      OP_LW:   w_isLoad  = 1'b1;
      OP_SW:   w_isStore = 1'b1;
      default: ;
    endcase
  end

  // FSM next state and bus outputs. w_advance marks the cycle in which an
  // instruction leaves EXEC, which is when the PC moves on.
  always_comb begin
    w_stateNext = r_state;
    read        = 1'b0;
    write       = 1'b0;
    address     = '0;
    writedata   = '0;
    w_rfWe      = 1'b0;
    w_rfWaddr   = w_wbAddr;
    w_rfWdata   = w_aluResult;
    w_advance   = 1'b0;
    case (r_state)
      FETCH: begin
        if (r_pc == 32'd0) begin
          w_stateNext = HALT;
        end else begin
          read    = 1'b1;
          address = r_pc;
          if (!waitrequest) w_stateNext = EXEC;
        end
      end
      EXEC: begin
        if (w_isLoad) begin
          read    = 1'b1;
          address = w_memAddr;
          if (!waitrequest) begin
            w_stateNext = MEM;
            w_advance   = 1'b1;
          end
        end else if (w_isStore) begin
          write     = 1'b1;
          address   = w_memAddr;
          writedata = byteSwap(w_rtVal);
          if (!waitrequest) begin
            w_stateNext = FETCH;
            w_advance   = 1'b1;
          end
        end else begin
          w_rfWe      = w_wbEn;
          w_stateNext = FETCH;
          w_advance   = 1'b1;
        end
      end
      MEM: begin
        w_rfWe      = 1'b1;
        w_rfWaddr   = r_ir[20:16];
        w_rfWdata   = byteSwap(readdata);
        w_stateNext = FETCH;
      end
      default: ;
    endcase
    // Keep the bus quiet while reset is held.
    if (!reset) begin
      read      = 1'b0;
      write     = 1'b0;
      address   = '0;
      writedata = '0;
    end
  end

  // State, PC and delay-slot bookkeeping. A control transfer is parked in
  // r_branchPending and only applied when the following instruction retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= FETCH;
      r_pc            <= RESET_VECTOR;
      r_ir            <= '0;
      r_stalled       <= 1'b0;
      r_branchPending <= 1'b0;
      r_branchTarget  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == EXEC) begin
        r_ir      <= w_instr;
        r_stalled <= !w_advance;
      end else begin
        r_stalled <= 1'b0;
      end
      if (w_advance) begin
        r_pc            <= r_branchPending ? r_branchTarget : w_pcPlus4;
        r_branchPending <= w_jump;
        r_branchTarget  <= w_jumpTarget;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// tb_mips_cpu_bus_core
// Directed programs run from a small bus memory model; results are checked
// against hand-computed register, bus and write-log values.
module tb_mips_cpu_bus_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] rom [0:15];
  logic [31:0] ram [0:15];
  logic [31:0] wrData [0:7];
  logic [31:0] wrAddr [0:7];
  int          wrCount;
  logic        skipHit;
  logic [31:0] skipAddr;

  int checks = 0;
  int errors = 0;

  mips_cpu_bus_core dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Bus memory: 0xBxxxxxxx maps to the program ROM, everything else to RAM.
  // Accepted reads return data the next cycle; accepted writes are logged.
  always @(posedge clk) begin
    if (!reset) begin
      wrCount <= 0;
      skipHit <= 1'b0;
    end else begin
      if (read && !waitrequest) begin
        readdata <= (address[31:28] == 4'hB) ? rom[address[5:2]] : ram[address[5:2]];
        if (address == skipAddr) skipHit <= 1'b1;
      end
      if (write && !waitrequest) begin
        ram[address[5:2]]     <= writedata;
        wrData[wrCount[2:0]] <= writedata;
        wrAddr[wrCount[2:0]] <= address;
        wrCount              <= wrCount + 1;
      end
    end
  end

  // Safety net in case something upstream stops advancing time.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] swapWord(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
  endtask

  task automatic loadWord(input int idx, input logic [31:0] instr);
    rom[idx] = swapWord(instr);
  endtask

  task automatic resetCpu();
    reset       = 1'b0;
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Run until the core drops active, bounded by maxCycles.
  task automatic applyStimulus(input string tag, input int maxCycles);
    int n = 0;
    while (active && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, active}, 32'd0);
  endtask

  task automatic waitForRead(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!(read && address == addr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, read && (address == addr)}, 32'd1);
  endtask

  // LUI $2,0xFFE1; ORI $2,$2,0xFF23; JR $0; NOP
  task automatic loadProgA();
    clearRom();
    loadWord(0, 32'h3C02FFE1);
    loadWord(1, 32'h3442FF23);
    loadWord(2, 32'h00000008);
    loadWord(3, 32'h00000000);
  endtask

  // ADDIU $2,$0,0x55; ORI $4,$0,0x100; ADDIU $3,$0,0x10; SW $3,0($4);
  // LW $2,0($4); JR $0; NOP
  task automatic loadProgB();
    clearRom();
    loadWord(0, 32'h24020055);
    loadWord(1, 32'h34040100);
    loadWord(2, 32'h24030010);
    loadWord(3, 32'hAC830000);
    loadWord(4, 32'h8C820000);
    loadWord(5, 32'h00000008);
    loadWord(6, 32'h00000000);
  endtask

  initial begin
    int haltReads;
    int stallBad;
    skipAddr    = 32'hFFFFFFFF;
    reset       = 1'b0;
    waitrequest = 1'b0;
    loadProgA();

    // Reset values on the bus
    repeat (3) @(negedge clk);
    checkOutput("rst_active", {31'b0, active}, 32'd1);
    checkOutput("rst_read", {31'b0, read}, 32'd0);
    checkOutput("rst_write", {31'b0, write}, 32'd0);
    checkOutput("rst_address", address, 32'd0);
    checkOutput("rst_writedata", writedata, 32'd0);
    checkOutput("rst_byteenable", {28'b0, byteenable}, 32'hF);
    checkOutput("rst_v0", register_v0, 32'd0);

    // First fetch right after release
    reset = 1'b1;
    #1;
    checkOutput("fetch0_read", {31'b0, read}, 32'd1);
    checkOutput("fetch0_address", address, 32'hBFC00000);
    checkOutput("fetch0_byteenable", {28'b0, byteenable}, 32'hF);

    // Program A: LUI/ORI then halt
    applyStimulus("progA_halt", 100);
    checkOutput("progA_v0", register_v0, 32'hFFE1FF23);
    haltReads = 0;
    repeat (5) begin
      @(negedge clk);
      if (read || write || active) haltReads++;
    end
    checkOutput("progA_quiet_after_halt", haltReads, 32'd0);

    // Program B: store then load through memory
    loadProgB();
    resetCpu();
    applyStimulus("progB_halt", 100);
    checkOutput("progB_wrcount", wrCount, 32'd1);
    checkOutput("progB_wraddr", wrAddr[0], 32'h00000100);
    checkOutput("progB_wrdata", wrData[0], 32'h10000000);
    checkOutput("progB_v0", register_v0, 32'h00000010);

    // Program C: ALU mix, results stored out
    clearRom();
    loadWord(0,  32'h2403FFFF);
    loadWord(1,  32'h30658001);
    loadWord(2,  32'h28660001);
    loadWord(3,  32'h0065382B);
    loadWord(4,  32'h00054100);
    loadWord(5,  32'h01051023);
    loadWord(6,  32'hAC050000);
    loadWord(7,  32'hAC060004);
    loadWord(8,  32'hAC070008);
    loadWord(9,  32'h00000008);
    loadWord(10, 32'h00000000);
    resetCpu();
    applyStimulus("progC_halt", 200);
    checkOutput("progC_wrcount", wrCount, 32'd3);
    checkOutput("progC_andi", wrData[0], 32'h01800000);
    checkOutput("progC_slti", wrData[1], 32'h01000000);
    checkOutput("progC_sltu", wrData[2], 32'h00000000);
    checkOutput("progC_addr2", wrAddr[2], 32'h00000008);
    checkOutput("progC_v0", register_v0, 32'h0007800F);

    // Program D: taken BEQ with a delay slot
    clearRom();
    loadWord(0, 32'h10000002);
    loadWord(1, 32'h24020005);
    loadWord(2, 32'h24420100);
    loadWord(3, 32'h00000008);
    loadWord(4, 32'h00000000);
    skipAddr = 32'hBFC00008;
    resetCpu();
    applyStimulus("progD_halt", 100);
    checkOutput("progD_v0", register_v0, 32'h00000005);
    checkOutput("progD_skipped", {31'b0, skipHit}, 32'd0);

    // Program E: JAL link value and delay slot
    clearRom();
    loadWord(0, 32'h0FF00004);
    loadWord(1, 32'h24020007);
    loadWord(2, 32'h24020009);
    loadWord(3, 32'h00000000);
    loadWord(4, 32'hAC1F0010);
    loadWord(5, 32'h00000008);
    loadWord(6, 32'h00000000);
    resetCpu();
    applyStimulus("progE_halt", 100);
    checkOutput("progE_v0", register_v0, 32'h00000007);
    checkOutput("progE_skipped", {31'b0, skipHit}, 32'd0);
    checkOutput("progE_link", wrData[0], 32'h0800C0BF);
    checkOutput("progE_linkaddr", wrAddr[0], 32'h00000010);
    skipAddr = 32'hFFFFFFFF;

    // Program A again with a 3-cycle stall on the second fetch
    loadProgA();
    resetCpu();
    waitForRead("stall_reach", 32'hBFC00004);
    waitrequest = 1'b1;
    stallBad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!(read && address == 32'hBFC00004 && !write)) stallBad++;
    end
    waitrequest = 1'b0;
    checkOutput("stall_bus_stable", stallBad, 32'd0);
    applyStimulus("stall_halt", 100);
    checkOutput("stall_v0", register_v0, 32'hFFE1FF23);

    // Program B with reset asserted while the LW sits in MEM
    loadProgB();
    resetCpu();
    waitForRead("mem_reach", 32'h00000100);
    @(negedge clk);
    checkOutput("mem_pre_v0", register_v0, 32'h00000055);
    reset = 1'b0;
    #1;
    checkOutput("mem_rst_active", {31'b0, active}, 32'd1);
    checkOutput("mem_rst_read", {31'b0, read}, 32'd0);
    checkOutput("mem_rst_address", address, 32'd0);
    checkOutput("mem_rst_v0", register_v0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mem_restart_pc", address, 32'hBFC00000);
    applyStimulus("mem_rerun_halt", 100);
    checkOutput("mem_rerun_v0", register_v0, 32'h00000010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
